// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: drives a single-outstanding data memory request,
// stalls the pipeline until completion, and reports misaligned accesses and timeouts.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  Size_in,
  input  logic        Unsigned_in,
  input  logic [31:0] Addr_in,
  input  logic [31:0] WriteData_in,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic [31:0] MemData_o,
  output logic        MEM_Stall,
  output logic        AddrErr,
  output logic        BusErr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_is_read;
  logic        r_dm_req;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [3:0]  r_dm_be;
  logic [31:0] r_dm_wdata;
  logic [31:0] r_mem_data;
  logic        r_addr_err;
  logic        r_bus_err;

  logic        w_access;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_timeout;

  assign w_access     = MemRead_in | MemWrite_in;
  // Reserved size 11 behaves as a word, hence Size_in[1] alone selects word checks.
  assign w_misaligned = ((Size_in == 2'b01) & Addr_in[0]) | (Size_in[1] & (|Addr_in[1:0]));
  assign w_timeout    = (r_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData_in;
    case (Size_in)
      2'b00: begin
        w_be    = 4'b0001 << Addr_in[1:0];
        w_wdata = {4{WriteData_in[7:0]}};
      end
      2'b01: begin
        w_be    = Addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection uses the offset captured at request time, not the live inputs.
  always_comb begin
    w_byte = dm_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = dm_rdata[15:8];
      2'd2:    w_byte = dm_rdata[23:16];
      2'd3:    w_byte = dm_rdata[31:24];
      default: w_byte = dm_rdata[7:0];
    endcase
    w_half = r_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_lane     <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_is_read  <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= 32'd0;
      r_dm_be    <= 4'd0;
      r_dm_wdata <= 32'd0;
      r_mem_data <= 32'd0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_misaligned) begin
              r_addr_err <= 1'b1;
              r_mem_data <= 32'd0;
            end else begin
              r_dm_req   <= 1'b1;
              r_dm_we    <= MemWrite_in;
              r_dm_addr  <= {Addr_in[31:2], 2'b00};
              // Byte enables qualify writes only; loads always fetch the full word.
              r_dm_be    <= MemWrite_in ? w_be : 4'b0000;
              r_dm_wdata <= w_wdata;
              r_cnt      <= 8'd0;
              r_lane     <= Addr_in[1:0];
              r_size     <= Size_in;
              r_unsigned <= Unsigned_in;
              r_is_read  <= MemRead_in & ~MemWrite_in;
              r_state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dm_ack) begin
            r_dm_req <= 1'b0;
            if (r_is_read) r_mem_data <= w_load;
            r_state  <= ST_DONE;
          end else if (w_timeout) begin
            r_dm_req   <= 1'b0;
            r_bus_err  <= 1'b1;
            r_mem_data <= 32'd0;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MEM_Stall = ~rst & (((r_state == ST_IDLE) & w_access & ~w_misaligned) |
                             (r_state == ST_WAIT));
  assign dm_req    = r_dm_req;
  assign dm_we     = r_dm_we;
  assign dm_addr   = r_dm_addr;
  assign dm_be     = r_dm_be;
  assign dm_wdata  = r_dm_wdata;
  assign MemData_o = r_mem_data;
  assign AddrErr   = r_addr_err;
  assign BusErr    = r_bus_err;

endmodule
